core_mc_ctrl: RTL and testbench
===============================

Name: core_mc_ctrl

Overview:
- Multi-cycle control FSM for core_v1: sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and a single memory port.
- Drives datapath mux selects and write enables, plus the ALU operation source; the ALU code itself comes from the ALU decoder when selected.
- Handles the memory valid/ready handshake with a wait-timeout.
- Traps on illegal opcode or memory timeout.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive wait cycles with mem_req=1 and mem_ready=0 before trapping.
- TMO_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- mem_ready  in  1  memory accepts/completes the current request this cycle
- cmp_eq  in  1  ALU compare: rs1 == rs2
- cmp_lt  in  1  ALU compare: rs1 < rs2 (signedness per ALU code)
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
- ir_we  out  1  latch fetched word into IR
- mdr_we  out  1  latch load data
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = branch/JAL target adder, 2 = ALU result & ~1
- reg_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = MDR, 2 = PC+4, 3 = U-immediate
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- alu_op_sel  out  2  0 = force ADD, 1 = ALU decoder output, 2 = branch compare code
- instret  out  1  one-cycle pulse per retired instruction
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Reset state is FETCH.
- While rst=1:
  - all outputs are 0 except state_o=0;
  - wait counter, taken flag and trap_cause are cleared.
  - First mem_req is asserted in the cycle after rst falls.
  - A reset mid-instruction abandons it; no write enable is asserted in the reset cycle.
- Outputs are Moore decodes of state and latched fields. Exceptions: ir_we and mdr_we equal mem_ready qualified by state.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1, go to DECODE.
- DECODE: classify opcode.
  - LUI 0110111 -> WB.
  - AUIPC, JAL, JALR, B, LOAD, STORE, I (0010011), R (0110011) -> EXEC.
  - Any other opcode -> TRAP, cause 1.
- EXEC, per class:
  - R: a=rs1, b=rs2, op=1.
  - I: a=rs1, b=imm, op=1.
  - AUIPC: a=PC, b=imm, op=0.
  - LOAD/STORE/JALR: a=rs1, b=imm, op=0.
  - B: a=rs1, b=rs2, op=2. Taken flag is registered at the end of EXEC:
    - BEQ: cmp_eq; BNE: !cmp_eq
    - BLT/BLTU: cmp_lt; BGE/BGEU: !cmp_lt
    - funct3 010 or 011 on a branch -> TRAP, cause 1
  - JAL: no ALU use.
  - Next state: LOAD/STORE -> MEM; all other classes -> WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - ALU select outputs are held at their EXEC values so the address stays stable.
  - On mem_ready: mdr_we=1 for LOAD only, go to WB.
- WB: pc_we=1 and instret=1. Per class:
  - pc_src: 1 for JAL and for a taken branch; 2 for JALR; 0 otherwise.
  - reg_we=1 except for B and STORE.
  - wb_sel: LUI 3, LOAD 1, JAL/JALR 2, else 0.
  - Next state: FETCH.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If it equals MEM_TIMEOUT and mem_ready=0, next state is TRAP, cause 2.
  - mem_ready in that same cycle wins and completes normally.
  - Counter saturates and never wraps.
- TRAP:
  - trap=1; all enables and mem_req are 0.
  - Held until rst; trap_cause keeps the first cause.
- Latency with zero-wait memory, counting from FETCH entry to the WB cycle inclusive:
  - LUI: 3 cycles
  - ALU/jump/branch: 4 cycles
  - load/store: 5 cycles
- No two write enables fire for different instructions in the same cycle. Exactly one instret per WB.

Test Plan:
- ADD (R, funct7=0), zero-wait memory -> states 0,1,2,4; in WB reg_we=1, wb_sel=0, pc_src=0, instret=1; mem_req=1 only in the FETCH cycle.
- BNE with cmp_eq=0 in EXEC, then cmp_eq toggled to 1 in WB -> pc_src=1 in WB (latched taken); repeat with cmp_eq=1 in EXEC -> pc_src=0, reg_we=0.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req, addr_sel=1 held for 4 cycles; mdr_we pulses on the ready cycle; WB has wb_sel=1.
- SW, MEM_TIMEOUT=4, mem_ready held 0 -> TRAP after 4 wait cycles, trap_cause=2, mem_req=0 thereafter; same run with mem_ready=1 on the 4th wait cycle -> no trap.
- Opcode 1111111 -> DECODE -> TRAP, cause 1, no pc_we or reg_we ever; branch opcode with funct3=010 -> TRAP, cause 1.
- rst asserted during MEM of a store -> mem_req=0 in the reset cycle, state_o=0; first mem_req with addr_sel=0 on the cycle after rst falls.

Source files
------------

// File: rtl/core_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_mc_ctrl
// Brief    : Multi-cycle control FSM for core_v1 (fetch/decode/exec/mem/wb,
//            memory handshake with wait-timeout, illegal-opcode trap).
// Revision : 1.0
// ============================================================================
module core_mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op_sel,
    output logic       instret,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        K_LUI, K_AUIPC, K_JAL, K_JALR, K_B, K_LOAD, K_STORE, K_I, K_R, K_ILL
    } kind_t;

    localparam logic [TMO_W-1:0] c_tmo = TMO_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    kind_t            r_kind;
    kind_t            w_dec_kind;
    logic             r_taken;
    logic             w_taken;
    logic             w_f3_bad;
    logic [TMO_W-1:0] r_cnt;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause;
    logic             w_wait;
    logic             w_tmo;

    always_comb begin
        w_dec_kind = K_ILL;
        case (opcode)
            7'b0110111: w_dec_kind = K_LUI;
            7'b0010111: w_dec_kind = K_AUIPC;
            7'b1101111: w_dec_kind = K_JAL;
            7'b1100111: w_dec_kind = K_JALR;
            7'b1100011: w_dec_kind = K_B;
            7'b0000011: w_dec_kind = K_LOAD;
            7'b0100011: w_dec_kind = K_STORE;
            7'b0010011: w_dec_kind = K_I;
            7'b0110011: w_dec_kind = K_R;
            default:    w_dec_kind = K_ILL;
        endcase
    end

    // funct3[0] inverts the sense; funct3[2] selects less-than over equality.
    assign w_taken  = funct3[0] ^ (funct3[2] ? cmp_lt : cmp_eq);
    assign w_f3_bad = (funct3[2:1] == 2'b01);

    assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_tmo  = w_wait && (r_cnt == c_tmo);

    always_comb begin
        w_next     = r_state;
        w_cause    = 2'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_we     = 1'b0;
        wb_sel     = 2'd0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op_sel = 2'd0;
        instret    = 1'b0;
        trap       = 1'b0;
        trap_cause = r_cause;
        state_o    = r_state;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd2;
                end
            end
            S_DECODE: begin
                if (w_dec_kind == K_ILL) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd1;
                end else if (w_dec_kind == K_LUI) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC, S_MEM: begin
                // MEM keeps the EXEC operand selects so the address is stable.
                alu_a_sel = (r_kind == K_AUIPC);
                alu_b_sel = (r_kind == K_I) || (r_kind == K_AUIPC) || (r_kind == K_LOAD) ||
                            (r_kind == K_STORE) || (r_kind == K_JALR);
                if ((r_kind == K_R) || (r_kind == K_I)) begin
                    alu_op_sel = 2'd1;
                end else if (r_kind == K_B) begin
                    alu_op_sel = 2'd2;
                end
                if (r_state == S_EXEC) begin
                    if ((r_kind == K_B) && w_f3_bad) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd1;
                    end else if ((r_kind == K_LOAD) || (r_kind == K_STORE)) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end else begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (r_kind == K_STORE);
                    mdr_we   = (r_kind == K_LOAD) && mem_ready;
                    if (mem_ready) begin
                        w_next = S_WB;
                    end else if (w_tmo) begin
                        w_next  = S_TRAP;
                        w_cause = 2'd2;
                    end
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                instret = 1'b1;
                if ((r_kind == K_JAL) || ((r_kind == K_B) && r_taken)) begin
                    pc_src = 2'd1;
                end else if (r_kind == K_JALR) begin
                    pc_src = 2'd2;
                end
                reg_we = (r_kind != K_B) && (r_kind != K_STORE);
                if (r_kind == K_LUI) begin
                    wb_sel = 2'd3;
                end else if (r_kind == K_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((r_kind == K_JAL) || (r_kind == K_JALR)) begin
                    wb_sel = 2'd2;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset masks every output, including a state that has not yet cleared.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_we      = 1'b0;
            mdr_we     = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            reg_we     = 1'b0;
            wb_sel     = 2'd0;
            alu_a_sel  = 1'b0;
            alu_b_sel  = 1'b0;
            alu_op_sel = 2'd0;
            instret    = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'd0;
            state_o    = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_kind  <= K_ILL;
            r_taken <= 1'b0;
            r_cnt   <= '0;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_kind <= w_dec_kind;
            end
            if ((r_state == S_EXEC) && (r_kind == K_B)) begin
                r_taken <= w_taken;
            end
            if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
                r_cnt <= '0;
            end else if (w_wait && (r_cnt != c_tmo)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_cause <= w_cause;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_mc_ctrl.sv
`default_nettype none
// tb_core_mc_ctrl: directed latency/trap checks plus randomized traffic,
// every cycle compared against an instruction-level reference model.
module tb_core_mc_ctrl;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       mem_ready = 1'b0;
    logic       cmp_eq = 1'b0;
    logic       cmp_lt = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we;
    logic       alu_a_sel, alu_b_sel, instret, trap;
    logic [1:0] pc_src, wb_sel, alu_op_sel, trap_cause;
    logic [2:0] state_o;

    core_mc_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op_sel(alu_op_sel), .instret(instret),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instruction classes, indexes into the attribute tables below.
    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_B = 4;
    localparam int K_LOAD = 5, K_STORE = 6, K_I = 7, K_R = 8, K_ILL = 9;
    int tab_a_pc [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int tab_b_imm[10] = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 0};
    int tab_op   [10] = '{0, 0, 0, 0, 2, 0, 0, 1, 1, 0};
    int tab_wb   [10] = '{3, 0, 2, 2, 0, 1, 0, 0, 0, 0};
    int tab_rwe  [10] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 0};
    logic [6:0] legal_ops[9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    function automatic int kind_of(input logic [6:0] op);
        for (int i = 0; i < 9; i++) begin
            if (legal_ops[i] == op) return i;
        end
        return K_ILL;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            default:        return !lt;
        endcase
    endfunction

    // Reference model: phase number equals the architectural state code.
    int   m_ph = 0;
    int   m_kind = K_ILL;
    int   m_wait = 0;
    int   m_cause = 0;
    logic m_taken = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0; m_wait <= 0; m_taken <= 1'b0; m_cause <= 0;
        end else begin
            case (m_ph)
                0, 3: begin
                    if (mem_ready) m_ph <= (m_ph == 0) ? 1 : 4;
                    else if (m_wait == TMO) begin m_ph <= 7; m_cause <= 2; end
                    else m_wait <= m_wait + 1;
                end
                1: begin
                    m_kind <= kind_of(opcode);
                    if (kind_of(opcode) == K_ILL) begin m_ph <= 7; m_cause <= 1; end
                    else m_ph <= (kind_of(opcode) == K_LUI) ? 4 : 2;
                end
                2: begin
                    if (m_kind == K_B && (funct3 == 3'b010 || funct3 == 3'b011)) begin
                        m_ph <= 7; m_cause <= 1;
                    end else if (m_kind == K_LOAD || m_kind == K_STORE) begin
                        m_ph <= 3; m_wait <= 0;
                    end else begin
                        m_ph <= 4;
                    end
                    if (m_kind == K_B) m_taken <= br_taken(funct3, cmp_eq, cmp_lt);
                end
                4: begin m_ph <= 0; m_wait <= 0; end
                default: m_ph <= 7;
            endcase
        end
    end

    logic [21:0] exp_v, act_v;
    logic [2:0]  e_state;
    logic [1:0]  e_pcsrc, e_wbsel, e_op, e_cause;
    logic        e_req, e_we, e_asel, e_irwe, e_mdrwe, e_pcwe, e_regwe, e_a, e_b, e_ret, e_trap;

    always @(negedge clk) begin
        e_state = 3'd0; e_pcsrc = 2'd0; e_wbsel = 2'd0; e_op = 2'd0; e_cause = 2'd0;
        e_req = 1'b0; e_we = 1'b0; e_asel = 1'b0; e_irwe = 1'b0; e_mdrwe = 1'b0;
        e_pcwe = 1'b0; e_regwe = 1'b0; e_a = 1'b0; e_b = 1'b0; e_ret = 1'b0; e_trap = 1'b0;
        if (!rst) begin
            e_state = 3'(m_ph);
            e_cause = 2'(m_cause);
            e_req   = (m_ph == 0) || (m_ph == 3);
            e_asel  = (m_ph == 3);
            e_we    = (m_ph == 3) && (m_kind == K_STORE);
            e_irwe  = (m_ph == 0) && mem_ready;
            e_mdrwe = (m_ph == 3) && (m_kind == K_LOAD) && mem_ready;
            e_trap  = (m_ph == 7);
            if (m_ph == 2 || m_ph == 3) begin
                e_a  = (tab_a_pc[m_kind] == 1);
                e_b  = (tab_b_imm[m_kind] == 1);
                e_op = 2'(tab_op[m_kind]);
            end
            if (m_ph == 4) begin
                e_pcwe  = 1'b1;
                e_ret   = 1'b1;
                e_regwe = (tab_rwe[m_kind] == 1);
                e_wbsel = 2'(tab_wb[m_kind]);
                if (m_kind == K_JAL || (m_kind == K_B && m_taken)) e_pcsrc = 2'd1;
                else if (m_kind == K_JALR) e_pcsrc = 2'd2;
            end
        end
        exp_v = {e_state, e_req, e_we, e_asel, e_irwe, e_mdrwe, e_pcwe, e_pcsrc, e_regwe,
                 e_wbsel, e_a, e_b, e_op, e_ret, e_trap, e_cause};
        act_v = {state_o, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_src, reg_we,
                 wb_sel, alu_a_sel, alu_b_sel, alu_op_sel, instret, trap, trap_cause};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t: got %06h expected %06h", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observations from the last directed instruction.
    int         lat, memcyc, reqcyc, mdr_n, wen_seen;
    logic [1:0] o_pcsrc, o_wbsel, o_cause;
    logic       o_regwe, o_trap, o_req;

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_state", int'(state_o), 0);
            chk("rst_mem_req", int'(mem_req), 0);
        end
    endtask

    // Runs one instruction from FETCH entry until retire or trap; MEM is held
    // not-ready for mdelay cycles; cmp_eq is eq_exec in EXEC and inverted elsewhere.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int mdelay, input logic eq_exec);
        int  mc;
        bit  done;
        mc = 0; done = 0; lat = 0; memcyc = 0; reqcyc = 0; mdr_n = 0; wen_seen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            if (m_ph == 0) begin opcode = op; funct3 = f3; end
            if (m_ph == 0)      mem_ready = 1'b1;
            else if (m_ph == 3) mem_ready = (mc >= mdelay);
            else                mem_ready = 1'($urandom_range(0, 1));
            if (m_ph == 3) mc++;
            cmp_eq = (m_ph == 2) ? eq_exec : !eq_exec;
            cmp_lt = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
            if (mem_req) reqcyc++;
            if (mem_req && addr_sel) memcyc++;
            if (mdr_we) mdr_n++;
            if (pc_we || reg_we) wen_seen++;
            if (instret || trap) begin
                done = 1;
                o_pcsrc = pc_src; o_wbsel = wb_sel; o_regwe = reg_we;
                o_trap = trap; o_cause = trap_cause; o_req = mem_req;
            end
        end
        chk("instr_completes", int'(done), 1);
    endtask

    bit reached_mem;
    bit slow;

    initial begin
        do_reset(2);

        run_instr(7'b0110111, 3'b000, 0, 1'b0);            // LUI
        chk("lui_latency", lat, 3);
        chk("lui_wb_sel", int'(o_wbsel), 3);

        run_instr(7'b0110011, 3'b000, 0, 1'b0);            // ADD
        chk("add_latency", lat, 4);
        chk("add_reg_we", int'(o_regwe), 1);
        chk("add_pc_src", int'(o_pcsrc), 0);
        chk("add_req_cycles", reqcyc, 1);

        run_instr(7'b1100011, 3'b001, 0, 1'b0);            // BNE taken
        chk("bne_taken_pc_src", int'(o_pcsrc), 1);
        chk("bne_latency", lat, 4);
        run_instr(7'b1100011, 3'b001, 0, 1'b1);            // BNE not taken
        chk("bne_nt_pc_src", int'(o_pcsrc), 0);
        chk("bne_nt_reg_we", int'(o_regwe), 0);

        run_instr(7'b0000011, 3'b010, 0, 1'b0);            // LW zero wait
        chk("lw_latency", lat, 5);
        run_instr(7'b0000011, 3'b010, 3, 1'b0);            // LW 3 waits
        chk("lw_mem_cycles", memcyc, 4);
        chk("lw_mdr_pulses", mdr_n, 1);
        chk("lw_wb_sel", int'(o_wbsel), 1);
        chk("lw_wait_latency", lat, 8);

        run_instr(7'b0100011, 3'b010, 3, 1'b0);            // SW ready on 4th wait cycle
        chk("sw_ready4_trap", int'(o_trap), 0);
        run_instr(7'b0100011, 3'b010, 4, 1'b0);            // ready when counter hits limit
        chk("sw_ready_at_limit_trap", int'(o_trap), 0);
        chk("sw_ready_at_limit_lat", lat, 9);
        run_instr(7'b0100011, 3'b010, 1000, 1'b0);         // never ready
        chk("sw_tmo_trap", int'(o_trap), 1);
        chk("sw_tmo_cause", int'(o_cause), 2);
        chk("sw_tmo_mem_cycles", memcyc, 5);
        chk("sw_tmo_req_after", int'(o_req), 0);
        repeat (3) @(negedge clk);
        chk("trap_sticky", int'(trap), 1);

        do_reset(1);
        run_instr(7'b1111111, 3'b000, 0, 1'b0);            // illegal opcode
        chk("ill_cause", int'(o_cause), 1);
        chk("ill_latency", lat, 3);
        chk("ill_no_wen", wen_seen, 0);

        do_reset(1);
        run_instr(7'b1100011, 3'b010, 0, 1'b0);            // branch funct3=010
        chk("br_f3_cause", int'(o_cause), 1);
        chk("br_f3_latency", lat, 4);

        do_reset(1);
        reached_mem = 0;
        for (int c = 0; c < 10 && !reached_mem; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            if (m_ph == 0) begin opcode = 7'b0100011; funct3 = 3'b010; end
            mem_ready = (m_ph != 3);
            if (m_ph == 3) reached_mem = 1;
        end
        chk("rst_mid_reached_mem", int'(reached_mem), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", int'(mem_req), 0);
        chk("rst_mid_mem_we", int'(mem_we), 0);
        chk("rst_mid_state", int'(state_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_req", int'(mem_req), 1);
        chk("post_rst_addr_sel", int'(addr_sel), 0);

        slow = 0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            if (c % 400 == 0) slow = ($urandom_range(0, 2) == 0);
            rst = (m_ph == 7 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
            if (m_ph == 0) begin
                opcode = ($urandom_range(0, 11) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
                funct3 = 3'($urandom);
            end
            mem_ready = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            cmp_eq = 1'($urandom_range(0, 1));
            cmp_lt = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
